image_read_stream: RTL and testbench

IMAGE_READ_STREAM -- requirements
Module: image_read_stream

---
 rtl/image_read_stream.sv | 277 +++++++++++++++++++++++++++
 tb/tb_image_read_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_read_stream.sv
// rtl/image_read_stream.sv - frame-memory reader streaming brightness/threshold-processed pixel beats
// Define BOTTOM_UP_EN to read source rows bottom-up; default build reads top-down.
module image_read_stream #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int PPC            = 2,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  localparam int AW            = $clog2(WIDTH*HEIGHT/PPC)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        value,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [24*PPC-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [24*PPC-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_sol,
  output logic              out_eol,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              busy,
  output logic              ctrl_done
);

  localparam int DW   = 24*PPC;
  localparam int EW   = DW + 4;
  localparam int WPL  = WIDTH/PPC;
  localparam int WW   = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int MAXD = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int CW   = $clog2(MAXD + 2);

  localparam logic [CW-1:0] VB_LAST   = CW'((START_UP_DELAY > 0) ? START_UP_DELAY - 1 : 0);
  localparam logic [CW-1:0] HB_LAST   = CW'((HSYNC_DELAY > 0) ? HSYNC_DELAY - 1 : 0);
  localparam logic [WW-1:0] WORD_LAST = WW'(WPL - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [AW-1:0] LINE_STEP = AW'(WPL);
`ifdef BOTTOM_UP_EN
  localparam logic [AW-1:0] BASE_INIT = AW'((HEIGHT - 1) * WPL);
`else
  localparam logic [AW-1:0] BASE_INIT = '0;
`endif

  typedef enum logic [2:0] {IDLE, VBLANK, HBLANK, LINE, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   blank_q, blank_d;
  logic [WW-1:0]   word_q, word_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   base_q, base_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      value_q, value_d;
  logic            mem_rd_q, mem_rd_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]      rd_flags_q, rd_flags_d;
  logic            pend_q, pend_d;
  logic [3:0]      pend_flags_q, pend_flags_d;
  logic            vsync_q, vsync_d;
  logic            hsync_q, hsync_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [EW-1:0]   fifo_q [4];
  logic [EW-1:0]   fifo_d [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;

  logic [DW-1:0]   proc_data;
  logic [EW-1:0]   head;
  logic [2:0]      in_use;
  logic            room;
  logic            pop;

  // Per-pixel operation; pixel is {R,G,B} with R in the top byte.
  function automatic logic [23:0] process_pixel(input logic [23:0] p, input logic [1:0] m,
                                                input logic [7:0] v);
    logic [23:0] r;
    logic [8:0]  t;
    logic [9:0]  sum;
    logic [9:0]  avg;
    r   = p;
    t   = '0;
    sum = 10'(p[23:16]) + 10'(p[15:8]) + 10'(p[7:0]);
    avg = sum / 10'd3;
    case (m)
      2'b01: begin
        for (int k = 0; k < 3; k++) begin
          t = {1'b0, p[8*k +: 8]} + {1'b0, v};
          r[8*k +: 8] = t[8] ? 8'hFF : t[7:0];
        end
      end
      2'b10: begin
        for (int k = 0; k < 3; k++) begin
          t = {1'b0, p[8*k +: 8]} - {1'b0, v};
          r[8*k +: 8] = t[8] ? 8'h00 : t[7:0];
        end
      end
      2'b11:   r = (avg > {2'b00, v}) ? 24'hFFFFFF : 24'h000000;
      default: r = p;
    endcase
    return r;
  endfunction

  always_comb begin
    proc_data = '0;
    for (int k = 0; k < PPC; k++) begin
      proc_data[24*k +: 24] = process_pixel(mem_rdata[24*k +: 24], mode_q, value_q);
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign out_valid = (count_q != 3'd0);
  assign pop       = out_valid && out_ready;
  // Reserve a FIFO slot for every read still travelling through the memory pipeline.
  assign in_use    = count_q + {2'b00, mem_rd_q} + {2'b00, pend_q};
  assign room      = (in_use < 3'd4);

  always_comb begin
    state_d      = state_q;
    blank_d      = blank_q;
    word_d       = word_q;
    row_d        = row_q;
    base_d       = base_q;
    mode_d       = mode_q;
    value_d      = value_q;
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    rd_flags_d   = 4'b0000;
    pend_d       = mem_rd_q;
    pend_flags_d = rd_flags_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = VBLANK;
          blank_d = '0;
          word_d  = '0;
          row_d   = '0;
          base_d  = BASE_INIT;
          mode_d  = mode;
          value_d = value;
        end
      end
      VBLANK: begin
        if (blank_q == VB_LAST) begin
          state_d = HBLANK;
          blank_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      HBLANK: begin
        if (blank_q == HB_LAST) begin
          state_d = LINE;
          blank_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      LINE: begin
        if (room) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = base_q + AW'(word_q);
          rd_flags_d = {(row_q == '0) && (word_q == '0),
                        (word_q == '0),
                        (word_q == WORD_LAST),
                        (row_q == ROW_LAST) && (word_q == WORD_LAST)};
          if (word_q == WORD_LAST) begin
            word_d = '0;
`ifdef BOTTOM_UP_EN
            base_d = base_q - LINE_STEP;
`else
            base_d = base_q + LINE_STEP;
`endif
            if (row_q == ROW_LAST) begin
              state_d = FLUSH;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = HBLANK;
              blank_d = '0;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (pop && head[DW]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    vsync_d = (state_d == VBLANK);
    hsync_d = (state_d == LINE);
    busy_d  = (state_d != IDLE);
    done_d  = pop && head[DW];
  end

  // Entries are {sof, sol, eol, eof, data}; data returns one cycle after the strobe.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pend_q) begin
      fifo_d[wr_ptr_q] = {pend_flags_q, proc_data};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b00, pend_q} - {2'b00, pop};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= IDLE;
      blank_q      <= '0;
      word_q       <= '0;
      row_q        <= '0;
      base_q       <= '0;
      mode_q       <= '0;
      value_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      rd_flags_q   <= '0;
      pend_q       <= 1'b0;
      pend_flags_q <= '0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      blank_q      <= blank_d;
      word_q       <= word_d;
      row_q        <= row_d;
      base_q       <= base_d;
      mode_q       <= mode_d;
      value_q      <= value_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      rd_flags_q   <= rd_flags_d;
      pend_q       <= pend_d;
      pend_flags_q <= pend_flags_d;
      vsync_q      <= vsync_d;
      hsync_q      <= hsync_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      for (int i = 0; i < 4; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_sof   = out_valid & head[DW+3];
  assign out_sol   = out_valid & head[DW+2];
  assign out_eol   = out_valid & head[DW+1];
  assign out_eof   = out_valid & head[DW];
  assign VSYNC     = vsync_q;
  assign HSYNC     = hsync_q;
  assign busy      = busy_q;
  assign ctrl_done = done_q;

endmodule

// File: tb/tb_image_read_stream.sv
// tb/tb_image_read_stream.sv - scoreboard bench for image_read_stream (8x4 image, PPC=2)
module tb_image_read_stream;

  localparam int WIDTH = 8;
  localparam int HEIGHT = 4;
  localparam int PPC = 2;
  localparam int SUD = 4;
  localparam int HSD = 3;
  localparam int AW = 4;
  localparam int DW = 48;
  localparam int NW = 16;
`ifdef BOTTOM_UP_EN
  localparam logic [3:0] FIRST_ADDR = 4'd12;
`else
  localparam logic [3:0] FIRST_ADDR = 4'd0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [7:0]    value = 8'd0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sof, out_eof, out_sol, out_eol;
  logic          VSYNC, HSYNC, busy, ctrl_done;

  image_read_stream #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PPC(PPC),
    .START_UP_DELAY(SUD), .HSYNC_DELAY(HSD)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .value(value),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .out_sol(out_sol), .out_eol(out_eol),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .busy(busy), .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_idx, beats, done_cnt, vs_cnt, first_rd_cyc, first_ov_cyc, last_beat_cyc;
  bit tp_check = 1'b0;
  logic [1:0] cur_mode;
  logic [7:0] cur_value;
  logic [DW-1:0] first_beat;
  logic [3:0] first_addr;
  logic [DW-1:0] img [NW];
  logic [51:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] px_model(input logic [23:0] p, input logic [1:0] m,
                                           input logic [7:0] v);
    int c [3];
    int s;
    logic [23:0] r;
    c[0] = int'(p[23:16]);
    c[1] = int'(p[15:8]);
    c[2] = int'(p[7:0]);
    r = p;
    case (m)
      2'b01: for (int k = 0; k < 3; k++) r[23-8*k -: 8] = 8'((c[k] + v > 255) ? 255 : c[k] + v);
      2'b10: for (int k = 0; k < 3; k++) r[23-8*k -: 8] = 8'((c[k] < v) ? 0 : c[k] - v);
      2'b11: begin
        s = (c[0] + c[1] + c[2]) / 3;
        r = (s > int'(v)) ? 24'hFFFFFF : 24'h000000;
      end
      default: r = p;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] exp_addr_of(input int idx);
`ifdef BOTTOM_UP_EN
    return 4'((HEIGHT - 1 - idx / 4) * 4 + idx % 4);
`else
    return 4'(idx);
`endif
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({mem_rd, mem_addr, out_valid, out_data, out_sof, out_sol, out_eol, out_eof,
                VSYNC, HSYNC, busy, ctrl_done});
  endfunction

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // Memory responder: data for a strobe seen in cycle t is presented throughout cycle t+1.
  initial begin
    logic [DW-1:0] nxt;
    forever begin
      @(negedge HCLK);
      nxt = mem_rd ? img[mem_addr] : '0;
      @(posedge HCLK);
      #1;
      mem_rdata = nxt;
    end
  end

  initial begin
    logic [3:0] ea;
    logic [DW-1:0] ed;
    logic [51:0] e;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        if (mem_rd) begin
          ea = exp_addr_of(rd_idx);
          check("mem_addr", 64'(mem_addr), 64'(ea));
          ed = {px_model(img[ea][47:24], cur_mode, cur_value),
                px_model(img[ea][23:0], cur_mode, cur_value)};
          exp_q.push_back({rd_idx == 0, rd_idx % 4 == 0, rd_idx % 4 == 3, rd_idx == NW - 1, ed});
          if (rd_idx == 0) begin
            first_rd_cyc = cyc;
            first_addr = mem_addr;
          end
          rd_idx++;
        end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(beats), 64'(NW));
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'({out_sof, out_sol, out_eol, out_eof, out_data}), 64'(e));
          end
          if (tp_check && !out_sol) check("throughput", 64'(cyc - last_beat_cyc), 64'd1);
          if (beats == 0) first_beat = out_data;
          last_beat_cyc = cyc;
          beats++;
        end
        if (ctrl_done) done_cnt++;
        if (VSYNC) vs_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic load_image();
    for (int a = 0; a < NW; a++) img[a] = 48'({$urandom(), $urandom()});
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [7:0] v);
    rd_idx = 0;
    beats = 0;
    done_cnt = 0;
    vs_cnt = 0;
    first_rd_cyc = -1;
    first_ov_cyc = -1;
    last_beat_cyc = 0;
    exp_q.delete();
    cur_mode = m;
    cur_value = v;
    mode = m;
    value = v;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    mode = ~m;
    value = ~v;
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      tick(1);
      n++;
    end
    tick(4);
    check({tag, "_done"}, 64'(done_cnt), 64'd1);
    check({tag, "_beats"}, 64'(beats), 64'(NW));
    check({tag, "_reads"}, 64'(rd_idx), 64'(NW));
    check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_vsync"}, 64'(vs_cnt), 64'(SUD));
    check({tag, "_latency"}, 64'(first_ov_cyc - first_rd_cyc), 64'd2);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    int n;

    tick(3);
    @(negedge HCLK);
    check("reset_outputs", out_vec(), 64'd0);
    tick(1);
    HRESET = 1'b0;
    tick(2);

    load_image();
    tp_check = 1'b1;
    start_frame(2'b00, 8'd0);
    tick(5);
    check("busy_mid", 64'(busy), 64'd1);
    mode = 2'b11;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    finish_frame("pass");
    check("pass_first_addr", 64'(first_addr), 64'(FIRST_ADDR));

    load_image();
    img[FIRST_ADDR][23:0] = {8'd200, 8'd10, 8'd155};
    start_frame(2'b01, 8'd100);
    finish_frame("add");
    check("add_pixel", 64'(first_beat[23:0]), 64'h00FF6EFF);

    load_image();
    img[FIRST_ADDR][23:0] = {8'd50, 8'd100, 8'd150};
    start_frame(2'b10, 8'd100);
    finish_frame("sub");
    check("sub_pixel", 64'(first_beat[23:0]), 64'h00000032);

    load_image();
    img[FIRST_ADDR] = {8'd91, 8'd91, 8'd91, 8'd90, 8'd90, 8'd91};
    start_frame(2'b11, 8'd90);
    finish_frame("thr");
    check("thr_pixels", 64'(first_beat), 64'h0000FFFFFF000000);

    load_image();
    tp_check = 1'b0;
    out_ready = 1'b0;
    start_frame(2'b00, 8'd0);
    n = 0;
    while (!out_valid && n < 200) begin
      tick(1);
      n++;
    end
    check("stall_valid", 64'(out_valid), 64'd1);
    held = 64'({out_valid, out_sof, out_sol, out_eol, out_eof, out_data});
    repeat (10) begin
      tick(1);
      check("stall_hold", 64'({out_valid, out_sof, out_sol, out_eol, out_eof, out_data}), held);
    end
    check("stall_reads", 64'(rd_idx), 64'd4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    out_ready = 1'b1;
    finish_frame("stall");

    load_image();
    tp_check = 1'b1;
    start_frame(2'b00, 8'd0);
    n = 0;
    while (rd_idx < 10 && n < 500) begin
      tick(1);
      n++;
    end
    check("mid_line2", 64'(rd_idx >= 10), 64'd1);
    HRESET = 1'b1;
    tick(1);
    @(negedge HCLK);
    check("reset_mid", out_vec(), 64'd0);
    tick(1);
    HRESET = 1'b0;
    tick(2);
    start_frame(2'b01, 8'd37);
    finish_frame("restart");
    check("restart_addr", 64'(first_addr), 64'(FIRST_ADDR));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
